// File: rtl/run_sequencer_if.sv
// Command/run handshake bundle between the host queue and node_control.
// The slave modport is the sequencer's view; master is the host/node side.
interface run_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_times;
    logic        run_write;
    logic [23:0] run_times;
    logic        running;

    modport master (
        output cmd_valid, cmd_times, running,
        input  cmd_ready, run_write, run_times
    );

    modport slave (
        input  cmd_valid, cmd_times, running,
        output cmd_ready, run_write, run_times
    );
endinterface

// File: rtl/run_sequencer.sv
// Queues run-batch commands and issues them one at a time to node_control.
// Define RUN_SEQ_NODE_RESET_EN to precede every run_write with a one-cycle node_reset.
module run_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    run_sequencer_if.slave                     bus,
    input  logic                               abort,
    input  logic                               irq_clear,
    output logic                               node_reset,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic [CNT_W-1:0]                   done_count,
    output logic                               irq,
    output logic                               err_zero
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE,
`ifdef RUN_SEQ_NODE_RESET_EN
        NRST,
`endif
        ISSUE,
        WAIT_START,
        BUSY
    } state_e;

    state_e             state_q, state_d;
    logic [23:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   count_q, count_d;
    logic               run_write_q, run_write_d;
    logic [23:0]        run_times_q, run_times_d;
    logic               node_reset_q, node_reset_d;
    logic [CNT_W-1:0]   done_q, done_d;
    logic               irq_q, irq_d, err_q, err_d;

    logic full, empty, hs, zero_cmd, push, pop, fin;

    assign full     = (count_q == LVL_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign hs       = bus.cmd_valid && !full;
    assign zero_cmd = hs && (bus.cmd_times == '0);
    // Zero-length commands and pushes that collide with abort complete the handshake but store nothing
    assign push     = hs && !zero_cmd && !abort;
    assign pop      = (state_q == ISSUE);

    always_comb begin
        state_d      = state_q;
        run_write_d  = 1'b0;
        run_times_d  = run_times_q;
        node_reset_d = 1'b0;
        fin          = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !abort) begin
`ifdef RUN_SEQ_NODE_RESET_EN
                    state_d      = NRST;
                    node_reset_d = 1'b1;
`else
                    state_d      = ISSUE;
                    run_write_d  = 1'b1;
                    run_times_d  = mem_q[rd_ptr_q];
`endif
                end
            end
`ifdef RUN_SEQ_NODE_RESET_EN
            NRST: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d     = ISSUE;
                    run_write_d = 1'b1;
                    run_times_d = mem_q[rd_ptr_q];
                end
            end
`endif
            ISSUE:      state_d = WAIT_START;
            WAIT_START: if (bus.running) state_d = BUSY;
            BUSY: begin
                if (!bus.running) begin
                    state_d = IDLE;
                    fin     = 1'b1;
                end
            end
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + LVL_W'(push) - LVL_W'(pop);
        end
        done_d = done_q + CNT_W'(fin);
        irq_d  = fin | (irq_q & ~irq_clear);
        err_d  = zero_cmd | (err_q & ~irq_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            run_write_q  <= 1'b0;
            run_times_q  <= '0;
            node_reset_q <= 1'b0;
            done_q       <= '0;
            irq_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            run_write_q  <= run_write_d;
            run_times_q  <= run_times_d;
            node_reset_q <= node_reset_d;
            done_q       <= done_d;
            irq_q        <= irq_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= bus.cmd_times;
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.run_write = run_write_q;
    assign bus.run_times = run_times_q;
    assign node_reset    = node_reset_q;
    assign busy          = (state_q != IDLE) || !empty;
    assign fifo_level    = count_q;
    assign done_count    = done_q;
    assign irq           = irq_q;
    assign err_zero      = err_q;
endmodule
